// File: rtl/net_guard_pkg.sv
// net_guard_pkg: shared state encoding and beat-limit helper for the egress guard.
package net_guard_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;
  function automatic int max_beats(input int len_bytes, input int bus_width);
    return (len_bytes * 8 + bus_width - 1) / bus_width;
  endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-stage forward-registered stream slice of generic payload width.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d, load;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    load    = in_valid && (!valid_q || out_ready);
    valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d  = load ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/egress_packet_guard.sv
// egress_packet_guard: truncates over-length AXI-Stream packets, pinning tid/tdest per packet.
// Optional counters stat_forced_tlast/stat_dropped_beats exist when EGRESS_PACKET_GUARD_STATS_EN is defined.
module egress_packet_guard
  import net_guard_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 3,
  parameter int AXIS_DEST_WIDTH   = 1,
  parameter int MAX_PACKET_LENGTH = 1522
) (
  input  logic                         axis_aclk,
  input  logic                         axis_aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]     axis_in_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]   axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]  axis_in_tkeep,
  input  logic                         axis_in_tlast,
  input  logic                         axis_in_tvalid,
  output logic                         axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [AXIS_ID_WIDTH-1:0]     axis_out_tid,
  output logic [AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
  output logic                         axis_out_tlast,
  output logic                         axis_out_tvalid,
  input  logic                         axis_out_tready
`ifdef EGRESS_PACKET_GUARD_STATS_EN
  ,
  output logic [31:0]                  stat_forced_tlast,
  output logic [31:0]                  stat_dropped_beats
`endif
);
  localparam int MAX_BEATS = max_beats(MAX_PACKET_LENGTH, AXIS_BUS_WIDTH);
  localparam int CW        = $clog2(MAX_BEATS + 1);
  localparam int PW        = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + AXIS_DEST_WIDTH + AXIS_BUS_WIDTH / 8 + 1;
  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [AXIS_ID_WIDTH-1:0]     id_q, id_d;
  logic [AXIS_DEST_WIDTH-1:0]   dest_q, dest_d;
  logic                         hs, fwd, at_max, last_out, forced;
  logic [PW-1:0]                in_payload, out_payload;
  always_comb begin
    hs         = axis_in_tvalid && axis_in_tready;
    fwd        = hs && state_q != DROP;
    at_max     = cnt_q == CW'(MAX_BEATS - 1);
    last_out   = axis_in_tlast || at_max;
    forced     = fwd && at_max && !axis_in_tlast;
    id_d       = state_q == IDLE ? axis_in_tid : id_q;
    dest_d     = state_q == IDLE ? axis_in_tdest : dest_q;
    cnt_d      = fwd ? (last_out ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d    = fwd ? (last_out ? (forced ? DROP : IDLE) : PASS)
                     : ((hs && axis_in_tlast) ? IDLE : state_q);
    in_payload = {axis_in_tdata, id_d, dest_d, axis_in_tkeep, last_out};
  end
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
    end
  end
  // Ready is held low through reset; DROP sinks beats regardless of the output side.
  assign axis_in_tready = axis_aresetn && (state_q == DROP || !axis_out_tvalid || axis_out_tready);
  axis_reg_slice #(.W(PW)) u_slice (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .in_valid  (fwd),
    .in_data   (in_payload),
    .out_ready (axis_out_tready),
    .out_valid (axis_out_tvalid),
    .out_data  (out_payload)
  );
  assign {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = out_payload;
`ifdef EGRESS_PACKET_GUARD_STATS_EN
  logic [31:0] forced_q, forced_d, dropped_q, dropped_d;
  always_comb begin
    forced_d  = (forced && ~&forced_q) ? forced_q + 32'd1 : forced_q;
    dropped_d = (hs && state_q == DROP && ~&dropped_q) ? dropped_q + 32'd1 : dropped_q;
  end
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      forced_q  <= '0;
      dropped_q <= '0;
    end else begin
      forced_q  <= forced_d;
      dropped_q <= dropped_d;
    end
  end
  assign stat_forced_tlast  = forced_q;
  assign stat_dropped_beats = dropped_q;
`endif
endmodule

// File: doc/egress_packet_guard.md
EGRESS_PACKET_GUARD -- requirements
Module: egress_packet_guard

Interface
REQ-001 The block SHALL have parameter AXIS_BUS_WIDTH, default 64, giving the stream data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter AXIS_ID_WIDTH, default 3, giving the tid width.
REQ-003 The block SHALL have parameter AXIS_DEST_WIDTH, default 1, giving the tdest width.
REQ-004 The block SHALL have parameter MAX_PACKET_LENGTH, default 1522, giving the maximum packet size in bytes; MAX_BEATS = ceil(MAX_PACKET_LENGTH*8/AXIS_BUS_WIDTH), which is 191 at the defaults.
REQ-005 The block SHALL have port axis_aclk, input, 1 bit: the single clock for all ports.
REQ-006 The block SHALL have port axis_aresetn, input, 1 bit: reset that is synchronous and active-low.
REQ-007 The block SHALL have ports axis_in_tdata/tid/tdest/tkeep/tlast/tvalid, inputs, of widths AXIS_BUS_WIDTH/AXIS_ID_WIDTH/AXIS_DEST_WIDTH/AXIS_BUS_WIDTH/8/1/1: the application egress stream.
REQ-008 The block SHALL have port axis_in_tready, output, 1 bit.
REQ-009 The block SHALL have ports axis_out_tdata/tid/tdest/tkeep/tlast/tvalid, outputs, with the same widths: the guarded stream towards the shell.
REQ-010 The block SHALL have port axis_out_tready, input, 1 bit.

Function
REQ-011 The block SHALL implement states IDLE (awaiting first beat), PASS (mid-packet) and DROP (discarding the tail of an over-length packet).
REQ-012 The block SHALL register the output: a single output register, latency of exactly 1 cycle from input handshake to axis_out_tvalid.
REQ-013 In IDLE/PASS the block SHALL drive axis_in_tready = !axis_out_tvalid || axis_out_tready, giving full throughput with no bubbles.
REQ-014 In DROP the block SHALL hold axis_in_tready = 1, SHALL discard accepted beats, and SHALL NOT assert axis_out_tvalid for them.
REQ-015 The block SHALL capture tid and tdest on the first accepted beat (IDLE) and drive those captured values on every output beat of the packet, ignoring later input tid/tdest changes.
REQ-016 The block SHALL keep a beat counter of width $clog2(MAX_BEATS+1); it SHALL increment on each PASS/IDLE handshake and clear on any output beat whose tlast=1.
REQ-017 When the block accepts beat number MAX_BEATS (counter == MAX_BEATS-1) with input tlast=0, it SHALL output that beat with tlast=1 and tkeep unchanged, then enter DROP.
REQ-018 When the block accepts beat MAX_BEATS with input tlast=1, it SHALL forward it normally and go to IDLE, with no DROP.
REQ-019 On an accepted beat with tlast=1 in DROP, the block SHALL go to IDLE; the next accepted beat starts a new packet.
REQ-020 A single-beat packet (tlast on the first beat) SHALL go IDLE -> IDLE, and tid/tdest SHALL be taken from that beat.
REQ-021 The block SHALL keep axis_out_* stable while axis_out_tvalid=1 and axis_out_tready=0.
REQ-022 A tkeep value of all zero SHALL be forwarded unmodified and SHALL still be counted as a beat.

Reset
REQ-023 While axis_aresetn=0 at a clock edge, the block SHALL set the state to IDLE, the counter to 0, and axis_out_tvalid, axis_out_tlast and axis_in_tready to 0; the data/tid/tdest/tkeep registers are don't-care.
REQ-024 Reset mid-packet SHALL abandon the packet without emitting a forced tlast; the first beat after reset SHALL be treated as a packet start.

Configuration
REQ-025 With macro EGRESS_PACKET_GUARD_STATS_EN defined, the block SHALL add output ports stat_forced_tlast [31:0] (count of REQ-017 events) and stat_dropped_beats [31:0] (count of beats discarded in DROP), both saturating at 32'hFFFFFFFF and reset to 0.
REQ-026 Without EGRESS_PACKET_GUARD_STATS_EN, the block SHALL have neither the counters nor their ports, and its behaviour SHALL otherwise be identical.

Structure
REQ-027 Package net_guard_pkg SHALL hold the state enum (IDLE, PASS, DROP) and a function computing MAX_BEATS from the length and width.
REQ-028 The output register SHALL be a sub-module axis_reg_slice that is parameterised on payload width; the FSM and counter SHALL live in egress_packet_guard.

Verification (defaults: 64-bit bus, MAX_BEATS = 191)
REQ-029 A 10-beat packet with tid=5, tdest=1 and constant tready SHALL produce the same 10 beats 1 cycle later, with tlast on beat 10 and no stall cycles.
REQ-030 A 200-beat packet SHALL produce an output of 191 beats with tlast on beat 191; beats 192-200 SHALL be dropped, and the next packet SHALL pass intact. With STATS_EN, forced=1 and dropped=9.
REQ-031 A packet of exactly 191 beats with tlast SHALL be forwarded unchanged, with no DROP state and forced=0.
REQ-032 When input tid changes from 2 to 6 at beat 3 of 5, all 5 output beats SHALL carry tid=2.
REQ-033 With axis_out_tready toggling 1/0 every cycle over 20 beats, the output SHALL be lossless and in order, and data SHALL stay stable on stalled cycles.
REQ-034 Reset asserted at beat 50 of a 100-beat packet SHALL give, after release, tvalid=0 and counter=0, and a following 3-beat packet SHALL pass with tlast on beat 3.
